serial_add_ctrl: RTL

//  Sequencer that adds two WIDTH-bit operands using one 2-bit add slice,
//  one 2-bit digit per clock, LSB digit first. Carry is held in a register

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Digit-serial adder sequencer: adds two WIDTH-bit operands through one 2-bit
// slice, LSB digit first, with a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;

    logic [CW:0]      dig_lsb;
    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [2:0]       slice;
    logic             last_dig;

    // Current digit selection and the single 2-bit add slice
    always_comb begin
        dig_lsb  = {cnt_q, 1'b0};
        a_dig    = a_q[dig_lsb +: 2];
        b_dig    = b_q[dig_lsb +: 2];
        slice    = {1'b0, a_dig} + {1'b0, b_dig} + {2'b00, carry_q};
        last_dig = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_dig) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[dig_lsb +: 2] <= slice[1:0];
                    carry_q             <= slice[2];
                    // Counter parks at zero after the last digit instead of wrapping
                    if (last_dig) begin
                        cout_q <= slice[2];
                        cnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
